inst_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the processor fetches from. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes each one to the instruction memory write port at consecutive word addresses. It holds the processor in reset until a complete, checksum-verified image has been written, then releases it. Sits between the external download link and the instruction memory, alongside the PC register.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/word_assembler.sv | 49 ++++
 rtl/inst_loader.sv | 146 ++++++++++++++
 tb/tb_inst_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared types and constants for the boot-time instruction loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  // Base of the processor's text segment.
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam int          CSUM_W    = 8;

endpackage

`default_nettype wire

// File: rtl/word_assembler.sv
// ============================================================================
// Module : word_assembler
// Brief  : Collects four bytes little-endian; flags the byte that fills a word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  // Only three bytes need storing; the fourth is taken straight off the input.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = {byte_in, shift_q[23:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word      = {byte_in, shift_q};
  assign word_full = byte_valid && (cnt_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// Module : inst_loader
// Brief  : Streams a checksummed image into instruction memory, then releases
//          the processor from reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TEXT_BASE,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         wcnt_q, wcnt_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic [15:0]         n_words;
  logic [31:0]         asm_word;
  logic                asm_full;

  assign accept  = in_valid && ready_q;
  assign n_words = {in_data, len_q[7:0]};

  word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (state_q == ST_WRITE),
    .byte_valid (accept && (state_q == ST_DATA)),
    .byte_in    (in_data),
    .word       (asm_word),
    .word_full  (asm_full)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_LEN0: if (accept) begin
        len_d[7:0] = in_data;
        csum_d     = csum_q + in_data;
        state_d    = ST_LEN1;
      end
      ST_LEN1: if (accept) begin
        len_d[15:8] = in_data;
        csum_d      = csum_q + in_data;
        if ({1'b0, n_words} > MAX_N) state_d = ST_ERR;
        else if (n_words == 16'd0)   state_d = ST_CSUM;
        else                         state_d = ST_DATA;
      end
      ST_DATA: if (accept) begin
        csum_d = csum_q + in_data;
        if (asm_full) begin
          wdata_d = asm_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 32'd4;
        wcnt_d  = wcnt_q + 16'd1;
        state_d = (wcnt_q + 16'd1 == len_q) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: if (accept) begin
        state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = state_q;
    endcase

    // Outputs are registered versions of what the next state implies.
    ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
              (state_d == ST_DATA) || (state_d == ST_CSUM);
    wr_en_d = (state_d == ST_WRITE);
    hold_d  = (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LEN0;
      len_q   <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = ready_q;
  assign mem_wr_en = wr_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// Module : tb_inst_loader
// Brief  : Directed self-checking bench for inst_loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  inst_loader dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log every write strobe seen mid-cycle.
  always @(negedge clock) begin
    if (reset && mem_wr_en) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte starting at a negedge; returns at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b);
    bit taken;
    taken    = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !taken; i++) begin
      if (in_ready) begin
        @(posedge clock);
        taken = 1'b1;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    if (!taken) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=%h expected=accept", b);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clock);
  endtask

  initial begin
    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_wr_en",     32'(mem_wr_en), 32'd0);
    check("rst_addr",      mem_addr,       32'h0040_0000);
    check("rst_wdata",     mem_wdata,      32'h0);
    check("rst_hold",      32'(cpu_hold),  32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Single word, full valid
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("sw_wr_latency", 32'(mem_wr_en), 32'd1);
    check("sw_ready_in_write", 32'(in_ready), 32'd0);
    check("sw_addr_live",  mem_addr,  32'h0040_0000);
    check("sw_wdata_live", mem_wdata, 32'h1234_5678);
    send_byte(8'h15);
    check("sw_done", 32'(done),     32'd1);
    check("sw_hold", 32'(cpu_hold), 32'd0);
    check("sw_nwr",  wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("sw_addr", wr_addr_q[0], 32'h0040_0000);
      check("sw_data", wr_data_q[0], 32'h1234_5678);
    end

    // Three words, in_valid toggling
    do_reset();
    begin
      logic [7:0] s3 [0:14];
      s3 = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hF3};
      for (int i = 0; i < 15; i++) begin
        send_byte(s3[i]);
        idle(1);
      end
    end
    check("tw_done",  32'(done),  32'd1);
    check("tw_error", 32'(error), 32'd0);
    check("tw_nwr",   wr_addr_q.size(), 32'd3);
    if (wr_addr_q.size() == 3) begin
      check("tw_addr0", wr_addr_q[0], 32'h0040_0000);
      check("tw_data0", wr_data_q[0], 32'h1122_3344);
      check("tw_addr1", wr_addr_q[1], 32'h0040_0004);
      check("tw_data1", wr_data_q[1], 32'hAABB_CCDD);
      check("tw_addr2", wr_addr_q[2], 32'h0040_0008);
      check("tw_data2", wr_data_q[2], 32'hDEAD_BEEF);
    end

    // Bad checksum
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h16);
    check("bc_error", 32'(error),    32'd1);
    check("bc_done",  32'(done),     32'd0);
    check("bc_hold",  32'(cpu_hold), 32'd1);
    check("bc_nwr",   wr_addr_q.size(), 32'd1);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    check("bc_ready_stuck", 32'(in_ready), 32'd0);
    check("bc_error_stuck", 32'(error),    32'd1);

    // Oversize length: 1025 words
    do_reset();
    send_byte(8'h01); send_byte(8'h04);
    check("ov_error", 32'(error),    32'd1);
    check("ov_ready", 32'(in_ready), 32'd0);
    check("ov_hold",  32'(cpu_hold), 32'd1);
    idle(3);
    check("ov_nwr",   wr_addr_q.size(), 32'd0);

    // Exactly MAX_WORDS is accepted
    do_reset();
    send_byte(8'h00); send_byte(8'h04);
    check("mx_error", 32'(error),    32'd0);
    check("mx_ready", 32'(in_ready), 32'd1);

    // Empty image
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("em_done", 32'(done),     32'd1);
    check("em_hold", 32'(cpu_hold), 32'd0);
    check("em_nwr",  wr_addr_q.size(), 32'd0);

    // Reset asserted during a WRITE pulse
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    #1 reset = 1'b0;
    #1;
    check("rw_wr_en", 32'(mem_wr_en), 32'd0);
    reset = 1'b1;

    // Reset mid-load on the 3rd byte of word 2
    do_reset();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'hB1); send_byte(8'hB2);
    in_data  = 8'hB3;
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    in_valid = 1'b0;
    check("rm_wr_en", 32'(mem_wr_en), 32'd0);
    check("rm_addr",  mem_addr,       32'h0040_0000);
    check("rm_hold",  32'(cpu_hold),  32'd1);
    check("rm_ready", 32'(in_ready),  32'd0);
    @(negedge clock);
    reset = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clock);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    send_byte(8'hC6);
    check("rm_done", 32'(done), 32'd1);
    check("rm_nwr",  wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("rm_addr2", wr_addr_q[0], 32'h0040_0000);
      check("rm_data2", wr_data_q[0], 32'hCAFE_F00D);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
